// File: rtl/spi2adc.sv
// spi2adc: SPI master that reads one 10-bit sample from an MCP3002 ADC per
// start pulse, then presents it with a one-cycle valid strobe.
// Every pin is a register loaded from the current state and counters, so the
// pins change one sysclk after the state that produces them. This is why CS
// falls one edge after start is accepted.
module spi2adc #(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       start,
    input  logic       channel,
    input  logic       adc_dout,
    output logic       adc_cs,
    output logic       adc_sck,
    output logic       adc_din,
    output logic [9:0] data_from_adc,
    output logic       data_valid,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_RECOVER
    } state_e;

    // Last count of one SCK half-period.
    localparam logic [7:0] CNT_LAST        = 8'(CLK_DIV - 1);
    // SHIFT covers half-periods 0..30. HOLD is the low half of clock 16.
    localparam logic [4:0] HALF_LAST       = 5'd30;
    // Half-periods whose rising edge carries D9 (edge 6) and D0 (edge 15).
    localparam logic [4:0] HALF_FIRST_DATA = 5'd10;
    localparam logic [4:0] HALF_LAST_DATA  = 5'd28;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [4:0] half_q, half_d;
    logic       chan_q, chan_d;
    logic [9:0] rx_q, rx_d;
    logic [9:0] data_q, data_d;
    logic       cs_q, cs_d;
    logic       sck_q, sck_d;
    logic       din_q, din_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;

    logic       phase_done;
    logic [5:0] half_p1;
    logic [4:0] clk_idx;
    logic       sample_edge;

    // MOSI bit for SCK clock idx (1..16): start, SGL, ODD, MSBF, then zeros.
    function automatic logic mosi_bit(input logic [4:0] idx, input logic ch);
        logic b;
        case (idx)
            5'd1, 5'd2, 5'd4: b = 1'b1;
            5'd3:             b = ch;
            default:          b = 1'b0;
        endcase
        return b;
    endfunction

    assign phase_done = (cnt_q == CNT_LAST);
    // Clock number whose MOSI bit is on the wire in this half-period.
    // It advances on each falling edge.
    assign half_p1    = {1'b0, half_q} + 6'd1;
    assign clk_idx    = half_p1[5:1] + 5'd1;
    // This is the cycle whose edge raises SCK, and the edge falls within D9..D0.
    assign sample_edge = (state_q == S_SHIFT) && !half_q[0] && (cnt_q == 8'd0) &&
                         (half_q >= HALF_FIRST_DATA) && (half_q <= HALF_LAST_DATA);

    // Next-state logic for the frame sequencer and the registered pin drivers.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case can infer a latch.
        state_d = state_q;
        cnt_d   = phase_done ? 8'd0 : cnt_q + 8'd1;
        half_d  = half_q;
        chan_d  = chan_q;
        rx_d    = rx_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = 8'd0;
                if (start) begin
                    state_d = S_SETUP;
                    chan_d  = channel;
                    rx_d    = '0;
                    half_d  = 5'd0;
                end
            end
            S_SETUP: begin
                if (phase_done) begin
                    state_d = S_SHIFT;
                    half_d  = 5'd0;
                end
            end
            S_SHIFT: begin
                if (sample_edge) begin
                    rx_d = {rx_q[8:0], adc_dout};
                end
                if (phase_done) begin
                    if (half_q == HALF_LAST) begin
                        state_d = S_HOLD;
                    end else begin
                        half_d = half_q + 5'd1;
                    end
                end
            end
            S_HOLD: begin
                if (phase_done) begin
                    state_d = S_RECOVER;
                end
            end
            S_RECOVER: begin
                if (phase_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The pins follow the current state. CS is low from SETUP through HOLD.
        cs_d    = !((state_q == S_SETUP) || (state_q == S_SHIFT) || (state_q == S_HOLD));
        sck_d   = (state_q == S_SHIFT) && !half_q[0];
        busy_d  = (state_q != S_IDLE);
        din_d   = 1'b0;
        if (state_q == S_SETUP) begin
            din_d = mosi_bit(5'd1, chan_q);
        end else if (state_q == S_SHIFT) begin
            din_d = mosi_bit(clk_idx, chan_q);
        end
        // The sample publishes on the edge where CS returns high.
        valid_d = cs_d && !cs_q;
        data_d  = valid_d ? rx_q : data_q;
    end

    // State and pin registers. A synchronous reset returns every pin to idle.
    always_ff @(posedge sysclk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            half_q  <= 5'd0;
            chan_q  <= 1'b0;
            rx_q    <= '0;
            data_q  <= '0;
            cs_q    <= 1'b1;
            sck_q   <= 1'b0;
            din_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            chan_q  <= chan_d;
            rx_q    <= rx_d;
            data_q  <= data_d;
            cs_q    <= cs_d;
            sck_q   <= sck_d;
            din_q   <= din_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign adc_cs        = cs_q;
    assign adc_sck       = sck_q;
    assign adc_din       = din_q;
    assign data_from_adc = data_q;
    assign data_valid    = valid_q;
    assign busy          = busy_q;

endmodule

// File: doc/spi2adc.md
# spi2adc

SPI master that reads one 10-bit sample from the board's MCP3002 two-channel ADC per request. It is the input-side counterpart of the existing SPI DAC writer. The shared `clkdiv` tick starts each conversion, so sampling runs at the same rate as DAC/PWM updates. The captured word is presented in parallel to downstream logic with a one-cycle valid strobe.

## Interface

Parameters:
- `CLK_DIV`, default 25: sysclk cycles per SCK half-period. SCK = sysclk/(2·CLK_DIV), giving 1 MHz at 50 MHz. Legal range 2..255.

Ports:
- `sysclk` in 1: system clock, 50 MHz.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: conversion request, a one-cycle pulse from `clkdiv`.
- `channel` in 1: 0 = CH0, 1 = CH1, single-ended.
- `adc_dout` in 1: MISO from the ADC.
- `adc_cs` out 1: chip select, active low.
- `adc_sck` out 1: SPI clock, idles low (mode 0,0).
- `adc_din` out 1: MOSI to the ADC.
- `data_from_adc` out 10: last completed sample.
- `data_valid` out 1: one-cycle strobe when `data_from_adc` updates.
- `busy` out 1: high while a frame or CS recovery is in progress.

## Operation

- Reset values: `adc_cs`=1, `adc_sck`=0, `adc_din`=0, `data_from_adc`=0, `data_valid`=0, `busy`=0, state IDLE.
- States:
  - IDLE to SETUP on `start`=1. `channel` is latched at this edge.
  - SETUP (CLK_DIV cycles, SCK low) to SHIFT.
  - SHIFT runs 16 SCK periods, then goes to HOLD.
  - HOLD (CLK_DIV cycles, SCK low, CS low) to RECOVER.
  - RECOVER (CLK_DIV cycles, CS high) to IDLE.
- `start` is ignored in every state except IDLE. There is no queueing.
- Frame is 16 SCK clocks, numbered 1..16. MOSI value for each clock:
  - Clock 1: 1 (start bit).
  - Clock 2: 1 (SGL).
  - Clock 3: latched channel (ODD).
  - Clock 4: 1 (MSBF).
  - Clocks 5..16: 0.
- MOSI for clock 1 is driven when CS falls. MOSI for clock k>1 changes on the falling SCK edge ending clock k−1.
- MISO is sampled on the sysclk edge at which SCK goes high:
  - Rising edges 6..15 shift in D9..D0, MSB first, into a 10-bit shift register.
  - Edge 5 (null bit) and edge 16 are discarded.
- `data_from_adc` loads from the shift register in the same cycle CS returns high. `data_valid` is high for exactly that cycle.
- A later `channel` change during a frame does not affect that frame.
- `reset` mid-frame: all outputs return to reset values at the next edge. The frame is abandoned, and `data_valid` is not pulsed.

## Timing

Let T0 be the edge that accepts `start`.
- T0+1: `adc_cs` falls, `busy` rises, `adc_din` = 1.
- SCK rising edge k at T0+1+CLK_DIV·(2k−1). Falling edge k at T0+1+CLK_DIV·2k.
- The 16th falling edge occurs at T0+1+32·CLK_DIV.
- T0+1+33·CLK_DIV: `adc_cs` rises, `data_valid`=1, `data_from_adc` updated. With CLK_DIV=25 this is cycle 826.
- `busy` falls CLK_DIV cycles later, at T0+1+34·CLK_DIV (851). The earliest next accepted `start` is at that edge.
- SCK duty cycle is exactly 50%. CS setup to first rising edge is CLK_DIV cycles. Last falling edge to CS high is CLK_DIV cycles. Minimum CS-high time is CLK_DIV cycles.
- Throughput: with `clkdiv` at 5000, one frame completes every 5000 cycles with 4149 idle cycles.

## Test plan

The bench includes a behavioural MCP3002 model: it samples MOSI on SCK rise and drives MISO on SCK fall.
1. Reset, then `start` with channel=0 and the model returning 10'h2A5. Expect `data_valid` at cycle 826, `data_from_adc`=10'h2A5, and MOSI clocks 1..4 = 1,1,0,1.
2. channel=1, model returns 10'h3FF then 10'h000 on consecutive ticks. Expect ODD bit 1 and words 3FF then 000. The last frame must not leak previous bits.
3. `start` pulses at cycles 100 and 850 relative to the first accepted start. Both are ignored: exactly one `data_valid`. A pulse at cycle 851 is accepted.
4. `reset` asserted at cycle 400 mid-frame. Next cycle: `adc_cs`=1, `adc_sck`=0, `data_from_adc`=0. No `data_valid`. A following `start` completes normally.
5. CLK_DIV=2: count exactly 16 SCK rising edges, each high phase 2 cycles, and `data_valid` at T0+67.
6. Toggle `channel` at cycle 50 mid-frame. The ODD bit still equals the latched value, and the model returns data for the latched channel.
